// File: rtl/multicycle_control_unit_if.sv
// Instruction-register inputs, datapath control strobes and debug state between
// the multi-cycle control unit (master) and the datapath (slave).
interface multicycle_control_unit_if #(
  parameter int ALUOP_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               pc_wr_en;
  logic               ir_wr_en;
  logic               iord;
  logic               mem_rd_en;
  logic               mem_wr_en;
  logic               reg_wr_en;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [2:0]         pc_src;
  logic               invalid_inst;
  logic               epc_wr_en;
  logic               timeout_err;
  logic [3:0]         state_o;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_wr_en, ir_wr_en, iord, mem_rd_en, mem_wr_en, reg_wr_en,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
           invalid_inst, epc_wr_en, timeout_err, state_o
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_wr_en, ir_wr_en, iord, mem_rd_en, mem_wr_en, reg_wr_en,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
           invalid_inst, epc_wr_en, timeout_err, state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM (3-5 cycles/instr, +1 per memory wait) with memory watchdog.
// Define CTRL_EXC_EN to route undefined instructions through TRAP (EPC load + exception vector).
module multicycle_control_unit #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADDR = 4'd2,  S_MEM_RD = 4'd3,
    S_MEM_WB   = 4'd4,  S_MEM_WR = 4'd5,  S_EXEC_R   = 4'd6,  S_R_WB   = 4'd7,
    S_BRANCH   = 4'd8,  S_JUMP   = 4'd9,  S_EXEC_I   = 4'd10, S_I_WB   = 4'd11,
    S_TRAP     = 4'd12, S_HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                         F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
                         F_NOR = 6'h27, F_SGT = 6'h29, F_SLT = 6'h2A;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0), ALU_SUB = ALUOP_W'(1),
                                 ALU_AND = ALUOP_W'(2), ALU_OR  = ALUOP_W'(3),
                                 ALU_SLT = ALUOP_W'(4), ALU_XOR = ALUOP_W'(5),
                                 ALU_NOR = ALUOP_W'(6), ALU_SLL = ALUOP_W'(7),
                                 ALU_SRL = ALUOP_W'(8), ALU_SGT = ALUOP_W'(9),
                                 ALU_NOP = '1;

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               r_ok, i_ok, is_jr, is_shift, wait_c, timeout_c;
  logic [ALUOP_W-1:0] r_alu, i_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Field decode shared by DECODE (legality) and the EXEC states (operation).
  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_NOP;
    unique case (bus.funct)
      F_ADD:   r_alu = ALU_ADD;
      F_SUB:   r_alu = ALU_SUB;
      F_AND:   r_alu = ALU_AND;
      F_OR:    r_alu = ALU_OR;
      F_SLT:   r_alu = ALU_SLT;
      F_SGT:   r_alu = ALU_SGT;
      F_XOR:   r_alu = ALU_XOR;
      F_NOR:   r_alu = ALU_NOR;
      F_SLL:   r_alu = ALU_SLL;
      F_SRL:   r_alu = ALU_SRL;
      default: r_ok  = 1'b0;
    endcase
    i_ok  = 1'b1;
    i_alu = ALU_NOP;
    unique case (bus.op)
      OP_ADDI: i_alu = ALU_ADD;
      OP_ANDI: i_alu = ALU_AND;
      OP_ORI:  i_alu = ALU_OR;
      OP_XORI: i_alu = ALU_XOR;
      OP_SLTI: i_alu = ALU_SLT;
      default: i_ok  = 1'b0;
    endcase
  end

  assign is_jr    = (bus.op == OP_R) && (bus.funct == F_JR);
  assign is_shift = (bus.funct == F_SLL) || (bus.funct == F_SRL);

  always_comb begin
    state_d          = state_q;
    bus.pc_wr_en     = 1'b0;
    bus.ir_wr_en     = 1'b0;
    bus.iord         = 1'b0;
    bus.mem_rd_en    = 1'b0;
    bus.mem_wr_en    = 1'b0;
    bus.reg_wr_en    = 1'b0;
    bus.reg_dst      = 2'd0;
    bus.mem_to_reg   = 2'd0;
    bus.alu_src_a    = 2'd0;
    bus.alu_src_b    = 2'd0;
    bus.alu_op       = ALU_NOP;
    bus.pc_src       = 3'd0;
    bus.invalid_inst = 1'b0;
    bus.epc_wr_en    = 1'b0;

    wait_c    = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                && !bus.mem_ready;
    timeout_c = (MEM_TIMEOUT > 0) && wait_c && (cnt_q == CNT_LAST);

    // Reset gates every strobe so nothing is written once rst_n falls.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_rd_en = 1'b1;
          bus.alu_src_b = 2'd1;
          bus.alu_op    = ALU_ADD;
          if (bus.mem_ready) begin
            bus.ir_wr_en = 1'b1;
            bus.pc_wr_en = 1'b1;
            state_d      = S_DECODE;
          end
        end
        S_DECODE: begin
          bus.alu_src_b = 2'd3;
          bus.alu_op    = ALU_ADD;
          if (is_jr)                                 state_d = S_JUMP;
          else if (bus.op == OP_R && r_ok)           state_d = S_EXEC_R;
          else if (bus.op == OP_LW || bus.op == OP_SW)   state_d = S_MEM_ADDR;
          else if (bus.op == OP_BEQ || bus.op == OP_BNE) state_d = S_BRANCH;
          else if (bus.op == OP_J || bus.op == OP_JAL)   state_d = S_JUMP;
          else if (i_ok)                             state_d = S_EXEC_I;
          else begin
            bus.invalid_inst = 1'b1;
`ifdef CTRL_EXC_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
`endif
          end
        end
        S_MEM_ADDR: begin
          bus.alu_src_a = 2'd1;
          bus.alu_src_b = 2'd2;
          bus.alu_op    = ALU_ADD;
          state_d       = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          bus.mem_rd_en = 1'b1;
          bus.iord      = 1'b1;
          if (bus.mem_ready) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          bus.reg_wr_en  = 1'b1;
          bus.mem_to_reg = 2'd1;
          state_d        = S_FETCH;
        end
        S_MEM_WR: begin
          bus.mem_wr_en = 1'b1;
          bus.iord      = 1'b1;
          if (bus.mem_ready) state_d = S_FETCH;
        end
        S_EXEC_R: begin
          bus.alu_src_a = is_shift ? 2'd2 : 2'd1;
          bus.alu_op    = r_alu;
          state_d       = S_R_WB;
        end
        S_R_WB: begin
          bus.reg_wr_en = 1'b1;
          bus.reg_dst   = 2'd1;
          state_d       = S_FETCH;
        end
        S_BRANCH: begin
          bus.alu_src_a = 2'd1;
          bus.alu_op    = ALU_SUB;
          bus.pc_src    = 3'd1;
          bus.pc_wr_en  = (bus.op == OP_BEQ) ? bus.zero : !bus.zero;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          bus.pc_wr_en = 1'b1;
          bus.pc_src   = is_jr ? 3'd3 : 3'd2;
          if (bus.op == OP_JAL) begin
            bus.reg_wr_en  = 1'b1;
            bus.reg_dst    = 2'd2;
            bus.mem_to_reg = 2'd2;
          end
          state_d = S_FETCH;
        end
        S_EXEC_I: begin
          bus.alu_src_a = 2'd1;
          bus.alu_src_b = 2'd2;
          bus.alu_op    = i_alu;
          state_d       = S_I_WB;
        end
        S_I_WB: begin
          bus.reg_wr_en = 1'b1;
          state_d       = S_FETCH;
        end
`ifdef CTRL_EXC_EN
        S_TRAP: begin
          bus.pc_wr_en  = 1'b1;
          bus.pc_src    = 3'd4;
          bus.epc_wr_en = 1'b1;
          state_d       = S_FETCH;
        end
`endif
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
      if (timeout_c) state_d = S_HALT;
    end

    cnt_d = (state_d != state_q) ? '0 : (wait_c ? cnt_q + CNT_W'(1) : cnt_q);
    err_d = err_q | timeout_c;
  end

  assign bus.timeout_err = err_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench: stimulus pushes hand-computed per-cycle expectations, a negedge monitor compares.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_wr_en, ir_wr_en, iord, mem_rd_en, mem_wr_en, reg_wr_en;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b;
    logic [3:0] alu_op;
    logic [2:0] pc_src;
    logic       invalid_inst, epc_wr_en, timeout_err;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALUOP_W(4)) bus ();

  multicycle_control_unit #(.ALUOP_W(4), .MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  outs_t exp_q[$];
  string nm_q[$];
  int    errors = 0;
  int    checks = 0;
  outs_t mon_a, mon_e, ev;
  string mon_n;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = nm_q.pop_front();
      mon_a = '{bus.state_o, bus.pc_wr_en, bus.ir_wr_en, bus.iord, bus.mem_rd_en,
                bus.mem_wr_en, bus.reg_wr_en, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_src, bus.invalid_inst, bus.epc_wr_en,
                bus.timeout_err};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", mon_n, mon_a, mon_e);
      end
    end
  end

  function automatic outs_t o_st(input logic [3:0] s);
    outs_t r;
    r        = '0;
    r.alu_op = 4'hF;
    r.st     = s;
    return r;
  endfunction

  function automatic outs_t o_fetch(input logic rdy);
    outs_t r;
    r           = o_st(4'd0);
    r.mem_rd_en = 1'b1;
    r.alu_src_b = 2'd1;
    r.alu_op    = 4'd0;
    r.ir_wr_en  = rdy;
    r.pc_wr_en  = rdy;
    return r;
  endfunction

  function automatic outs_t o_decode();
    outs_t r;
    r           = o_st(4'd1);
    r.alu_src_b = 2'd3;
    r.alu_op    = 4'd0;
    return r;
  endfunction

  task automatic step(input string nm, input outs_t e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fd(input string p);
    bus.mem_ready = 1'b1;
    step({p, ".fetch"}, o_fetch(1'b1));
    step({p, ".decode"}, o_decode());
  endtask

  initial begin
    bus.op = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    step("reset0", o_st(4'd0));
    step("reset1", o_st(4'd0));
    rst_n = 1'b1;

    // add: 0,1,6,7
    bus.op = 6'h00; bus.funct = 6'h20; fd("add");
    ev = o_st(4'd6); ev.alu_src_a = 2'd1; ev.alu_op = 4'd0; step("add.exec", ev);
    ev = o_st(4'd7); ev.reg_wr_en = 1'b1; ev.reg_dst = 2'd1; step("add.wb", ev);

    // sll selects shamt
    bus.funct = 6'h00; fd("sll");
    ev = o_st(4'd6); ev.alu_src_a = 2'd2; ev.alu_op = 4'd7; step("sll.exec", ev);
    ev = o_st(4'd7); ev.reg_wr_en = 1'b1; ev.reg_dst = 2'd1; step("sll.wb", ev);

    // lw with 3 wait cycles in MEM_RD: 8 cycles total
    bus.op = 6'h23; fd("lw");
    ev = o_st(4'd2); ev.alu_src_a = 2'd1; ev.alu_src_b = 2'd2; ev.alu_op = 4'd0;
    step("lw.addr", ev);
    ev = o_st(4'd3); ev.mem_rd_en = 1'b1; ev.iord = 1'b1;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw.rd_wait", ev);
    bus.mem_ready = 1'b1;
    step("lw.rd", ev);
    ev = o_st(4'd4); ev.reg_wr_en = 1'b1; ev.mem_to_reg = 2'd1; step("lw.wb", ev);

    // sw with one wait cycle
    bus.op = 6'h2B; fd("sw");
    ev = o_st(4'd2); ev.alu_src_a = 2'd1; ev.alu_src_b = 2'd2; ev.alu_op = 4'd0;
    step("sw.addr", ev);
    ev = o_st(4'd5); ev.mem_wr_en = 1'b1; ev.iord = 1'b1;
    bus.mem_ready = 1'b0; step("sw.wr_wait", ev);
    bus.mem_ready = 1'b1; step("sw.wr", ev);

    // beq / bne with zero=1, then bne with zero=0
    bus.zero = 1'b1;
    bus.op = 6'h04; fd("beq");
    ev = o_st(4'd8); ev.alu_src_a = 2'd1; ev.alu_op = 4'd1; ev.pc_src = 3'd1; ev.pc_wr_en = 1'b1;
    step("beq.taken", ev);
    bus.op = 6'h05; fd("bne");
    ev.pc_wr_en = 1'b0; step("bne.nottaken", ev);
    bus.zero = 1'b0; fd("bne0");
    ev.pc_wr_en = 1'b1; step("bne.taken", ev);

    // jal and jr
    bus.op = 6'h03; fd("jal");
    ev = o_st(4'd9); ev.pc_wr_en = 1'b1; ev.pc_src = 3'd2; ev.reg_wr_en = 1'b1;
    ev.reg_dst = 2'd2; ev.mem_to_reg = 2'd2; step("jal.jump", ev);
    bus.op = 6'h00; bus.funct = 6'h08; fd("jr");
    ev = o_st(4'd9); ev.pc_wr_en = 1'b1; ev.pc_src = 3'd3; step("jr.jump", ev);

    // ori
    bus.op = 6'h0D; fd("ori");
    ev = o_st(4'd10); ev.alu_src_a = 2'd1; ev.alu_src_b = 2'd2; ev.alu_op = 4'd3;
    step("ori.exec", ev);
    ev = o_st(4'd11); ev.reg_wr_en = 1'b1; step("ori.wb", ev);

    // undefined opcode
    bus.op = 6'h3F;
    step("inv.fetch", o_fetch(1'b1));
    ev = o_decode(); ev.invalid_inst = 1'b1; step("inv.decode", ev);
`ifdef CTRL_EXC_EN
    ev = o_st(4'd12); ev.pc_wr_en = 1'b1; ev.pc_src = 3'd4; ev.epc_wr_en = 1'b1;
    step("inv.trap", ev);
`endif

    // 14 waits then ready on the limit cycle: ready wins, j proceeds
    bus.op = 6'h02; bus.mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step("edge.fetch_wait", o_fetch(1'b0));
    bus.mem_ready = 1'b1;
    step("edge.fetch_ready", o_fetch(1'b1));
    step("edge.decode", o_decode());
    ev = o_st(4'd9); ev.pc_wr_en = 1'b1; ev.pc_src = 3'd2; step("j.jump", ev);

    // reset mid-instruction (in R_WB) kills the write strobe
    bus.op = 6'h00; bus.funct = 6'h22; fd("sub");
    ev = o_st(4'd6); ev.alu_src_a = 2'd1; ev.alu_op = 4'd1; step("sub.exec", ev);
    rst_n = 1'b0;
    step("abort.reset", o_st(4'd0));
    rst_n = 1'b1;

    // watchdog: 15 not-ready FETCH cycles then HALT, sticky
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("wd.fetch_wait", o_fetch(1'b0));
    ev = o_st(4'd13); ev.timeout_err = 1'b1;
    step("wd.halt0", ev);
    step("wd.halt1", ev);
    bus.mem_ready = 1'b1;
    step("wd.halt_ready0", ev);
    step("wd.halt_ready1", ev);
    rst_n = 1'b0;
    step("wd.reset", o_st(4'd0));
    rst_n = 1'b1;
    step("wd.refetch", o_fetch(1'b1));
    step("wd.redecode", o_decode());

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

- Multi-cycle successor to the single-cycle decoder: an FSM that sequences one MIPS instruction over 3–5 cycles and drives the shared-ALU/shared-memory datapath.
- Adds a memory ready handshake with a watchdog timeout, and a width-parametrised ALU opcode.
- Adds `jr` as a proper R-type instruction (funct 0x08).
- Sits between the instruction register and the multi-cycle datapath muxes, PC enable and register file.

## Interface

Parameters:
- ALUOP_W, default 4: ALU opcode width, must be ≥4. Codes are zero-extended; NOP is all-ones.
- MEM_TIMEOUT, default 15: number of consecutive not-ready memory cycles before HALT. 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  opcode from the instruction register; stable from DECODE to the next FETCH
- funct  in  6  funct field from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read or write
- pc_wr_en  out  1  PC write strobe
- ir_wr_en  out  1  instruction register load
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_rd_en  out  1  memory read request
- mem_wr_en  out  1  memory write request
- reg_wr_en  out  1  register file write
- reg_dst  out  2  destination select: 0 = rt, 1 = rd, 2 = $31
- mem_to_reg  out  2  write-back select: 0 = ALUOut, 1 = MDR, 2 = PC
- alu_src_a  out  2  ALU A select: 0 = PC, 1 = rs, 2 = shamt
- alu_src_b  out  2  ALU B select: 0 = rt, 1 = constant 4, 2 = sign-extended imm, 3 = imm<<2
- alu_op  out  ALUOP_W  ALU operation
- pc_src  out  3  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target, 3 = rs, 4 = exception vector
- invalid_inst  out  1  one-cycle pulse when an undefined instruction is decoded
- epc_wr_en  out  1  EPC load (exception build only)
- timeout_err  out  1  sticky memory-timeout flag
- state_o  out  4  current FSM state, for debug

## Operation

ALU opcodes:
- add=0, sub=1, and=2, or=3, slt=4, xor=5, nor=6, sll=7, srl=8, sgt=9, NOP=all-ones.

Decoded instructions:
- R-type (op 0): funct 20 add, 22 sub, 24 and, 25 or, 2A slt, 29 sgt, 26 xor, 27 nor, 00 sll, 02 srl, 08 jr.
- I-type and others: 08 addi, 0C andi, 0D ori, 0E xori, 0A slti, 23 lw, 2B sw, 04 beq, 05 bne, 02 j, 03 jal.

FSM states (encoding in brackets):
- FETCH(0): mem_rd_en=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=add.
  - In the cycle mem_ready=1: ir_wr_en=1, pc_wr_en=1, pc_src=0, next state DECODE.
- DECODE(1): alu_src_a=0, alu_src_b=3, add (branch target into ALUOut). Next state by op:
  - R-type (except jr) → EXEC_R
  - jr → JUMP
  - lw, sw → MEM_ADDR
  - beq, bne → BRANCH
  - j, jal → JUMP
  - immediate ALU → EXEC_I
  - undefined → invalid_inst=1, then FETCH (or TRAP when exceptions are enabled)
- MEM_ADDR(2): alu_src_a=1, alu_src_b=2, add. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD(3): mem_rd_en=1, iord=1. Advances to MEM_WB on mem_ready.
- MEM_WB(4): reg_wr_en=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WR(5): mem_wr_en=1, iord=1. Advances to FETCH on mem_ready.
- EXEC_R(6): alu_src_a=1 (2 for sll/srl), alu_src_b=0, alu_op per funct. Next R_WB.
- R_WB(7): reg_wr_en=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=0, sub, pc_src=1.
  - pc_wr_en = zero for beq, !zero for bne.
  - Next FETCH.
- JUMP(9): pc_wr_en=1.
  - pc_src=3 for jr, 2 otherwise.
  - jal additionally drives reg_wr_en=1, reg_dst=2, mem_to_reg=2.
  - Next FETCH.
- EXEC_I(10): alu_src_a=1, alu_src_b=2, alu_op per opcode. Next I_WB.
- I_WB(11): reg_wr_en=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- TRAP(12): pc_wr_en=1, pc_src=4, epc_wr_en=1. Next FETCH.
- HALT(13): all strobes 0. Left only by reset.

Defaults:
- Any output not named for a state is 0; alu_op defaults to NOP.

Watchdog:
- The wait counter is $clog2(MEM_TIMEOUT+1) bits wide.
- Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
- Clears on every state change.
- Reaching MEM_TIMEOUT → next state HALT, timeout_err←1.
- mem_ready=1 in the same cycle as reaching the limit: ready wins, normal advance.

## Timing

- Outputs are combinational from the state register, op/funct, zero and mem_ready. Handshake strobes are Mealy on mem_ready.
- Latency with zero memory wait:
  - branch, j, jal, jr: 3 cycles
  - R-type, I-type ALU, sw: 4 cycles
  - lw: 5 cycles
- Each not-ready memory cycle adds 1 cycle.
- While rst_n=0, and on the first cycle after release:
  - state=FETCH, counter=0, timeout_err=0.
  - During reset, all strobes and selects are forced to 0 and alu_op to NOP.
- Reset asserted mid-instruction aborts immediately: no write strobe is asserted after rst_n falls.
- mem_rd_en / mem_wr_en are held constant until mem_ready is sampled high.

## Configuration

- CTRL_EXC_EN defined: an undefined instruction goes DECODE → TRAP → FETCH. invalid_inst pulses in DECODE.
- CTRL_EXC_EN undefined: an undefined instruction goes DECODE → FETCH and executes as a NOP. TRAP is unreachable and epc_wr_en is tied 0.

## Test plan

- add (op 00, funct 20), mem_ready always 1 → states 0,1,6,7,0; reg_wr_en=1 with reg_dst=1 only in cycle 4; alu_op=0 in EXEC_R.
- lw (op 23), mem_ready low for 3 cycles in MEM_RD → mem_rd_en and iord=1 held for 4 cycles; total latency 8 cycles; MEM_WB has mem_to_reg=1.
- beq with zero=1, then bne with zero=1 → pc_wr_en=1 with pc_src=1 for the beq; pc_wr_en=0 for the bne; 3 cycles each.
- jal (op 03) → JUMP: pc_src=2, reg_dst=2, mem_to_reg=2, reg_wr_en=1. jr (funct 08) → pc_src=3, reg_wr_en=0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 → HALT after 15 wait cycles; timeout_err=1 and sticky. rst_n pulse → FETCH, timeout_err=0.
- op 3F, with and without CTRL_EXC_EN → invalid_inst pulses 1 cycle.
  - With the macro: TRAP asserts epc_wr_en=1, pc_src=4.
  - Without the macro: returns directly to FETCH; no register or memory write.
